palette_lookup_arbiter: RTL

- Shares one 16-entry, 24-bit sprite palette (e.g. bullet palette, index 0 = transparent) among N_REQ sprite pixel requesters.
- Round-robin arbitration, one lookup per cycle; 2-stage pipeline returns the RGB colour plus a transparent flag, tagged with requester id and pixel tag.
- Sits between the sprite decoders and the frame compositor; the palette module's colour-map output drives i_color_map.

---
 rtl/palette_lookup_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/palette_lookup_arbiter.sv
// palette_lookup_arbiter
//   Shares one 16-entry palette among N_REQ sprite pixel requesters.
//   Round-robin grant (one per cycle) feeds a 2-stage pipeline:
//   S1 holds the granted request, S2/output holds colour + transparent flag.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_color_map[0:15]     palette contents, sampled when S2 loads
//   i_req_valid/idx/tag   per-requester request, flat-packed per requester
//   o_req_ready           one-hot grant (zero when stalled or idle)
//   o_rsp_*               response; held while o_rsp_valid & !i_rsp_ready
//   o_busy                a lookup is in S1 or on the output
module palette_lookup_arbiter #(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 4,
  parameter int COLOR_W = 24,
  parameter int TAG_W   = 10,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [COLOR_W-1:0]       i_color_map [0:15],
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*IDX_W-1:0]   i_req_idx,
  input  logic [N_REQ*TAG_W-1:0]   i_req_tag,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [TAG_W-1:0]         o_rsp_tag,
  output logic [COLOR_W-1:0]       o_rsp_color,
  output logic                     o_rsp_transparent,
  output logic                     o_busy
);

  localparam int STAGES = 2;

  // Flat request buses viewed as per-requester lanes.
  logic [N_REQ-1:0][IDX_W-1:0] req_idx;
  logic [N_REQ-1:0][TAG_W-1:0] req_tag;
  assign req_idx = i_req_idx;
  assign req_tag = i_req_tag;

  // vld_pipe[1] = S1 occupied, vld_pipe[2] = output occupied.
  // The stage-0 valid is the combinational accept strobe.
  logic [STAGES:1]    vld_pipe_q, vld_pipe_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;
  logic [IDX_W-1:0]   s1_idx_q, s1_idx_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic [COLOR_W-1:0] rsp_color_q, rsp_color_d;
  logic               rsp_transp_q, rsp_transp_d;

  logic               s1_adv, s2_adv, found, acc;
  logic [ID_W-1:0]    grant, cand;
  logic [ID_W:0]      sum;

  // Round-robin search starting at ptr; candidate index wraps mod N_REQ
  // without a divider so non-power-of-two N_REQ works.
  always_comb begin
    s2_adv = !vld_pipe_q[2] | i_rsp_ready;
    s1_adv = !vld_pipe_q[1] | s2_adv;
    found  = 1'b0;
    grant  = '0;
    sum    = '0;
    cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
      cand = sum[ID_W-1:0];
      if (!found && i_req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
    acc         = s1_adv & found;
    o_req_ready = '0;
    if (acc) o_req_ready[grant] = 1'b1;
  end

  always_comb begin
    ptr_d        = ptr_q;
    vld_pipe_d   = vld_pipe_q;
    s1_id_d      = s1_id_q;
    s1_idx_d     = s1_idx_q;
    s1_tag_d     = s1_tag_q;
    rsp_id_d     = rsp_id_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_color_d  = rsp_color_q;
    rsp_transp_d = rsp_transp_q;

    if (acc) begin
      ptr_d    = (grant == ID_W'(N_REQ-1)) ? '0 : grant + ID_W'(1);
      s1_id_d  = grant;
      s1_idx_d = req_idx[grant];
      s1_tag_d = req_tag[grant];
    end
    if (s1_adv) vld_pipe_d[1] = acc;

    if (s2_adv) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      // Data only reloads on a real lookup; bubbles leave it unchanged.
      if (vld_pipe_q[1]) begin
        rsp_id_d     = s1_id_q;
        rsp_tag_d    = s1_tag_q;
        rsp_transp_d = (s1_idx_q == '0);
        rsp_color_d  = (s1_idx_q == '0) ? '0 : i_color_map[s1_idx_q];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe_q   <= '0;
      ptr_q        <= '0;
      s1_id_q      <= '0;
      s1_idx_q     <= '0;
      s1_tag_q     <= '0;
      rsp_id_q     <= '0;
      rsp_tag_q    <= '0;
      rsp_color_q  <= '0;
      rsp_transp_q <= 1'b0;
    end else begin
      vld_pipe_q   <= vld_pipe_d;
      ptr_q        <= ptr_d;
      s1_id_q      <= s1_id_d;
      s1_idx_q     <= s1_idx_d;
      s1_tag_q     <= s1_tag_d;
      rsp_id_q     <= rsp_id_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_color_q  <= rsp_color_d;
      rsp_transp_q <= rsp_transp_d;
    end
  end

  assign o_rsp_valid       = vld_pipe_q[2];
  assign o_rsp_id          = rsp_id_q;
  assign o_rsp_tag         = rsp_tag_q;
  assign o_rsp_color       = rsp_color_q;
  assign o_rsp_transparent = rsp_transp_q;
  assign o_busy            = |vld_pipe_q;

endmodule
